captura_digitos: RTL

CAPTURA_DIGITOS -- requirements
Module: captura_digitos

---
 rtl/captura_digitos.sv | 116 +++++++++++
 1 files changed

// File: rtl/captura_digitos.sv
// Keypad digit capture: one keystroke per key-down interval, three-digit BCD entry buffer,
// clear/enter handling and a committed value with a one-cycle valid pulse.
module captura_digitos #(
  parameter int unsigned RELEASE_CYC = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  boton,
  input  logic        ctrl,
  output logic [11:0] digitos,
  output logic [1:0]  num_dig,
  output logic        lleno,
  output logic [11:0] valor,
  output logic        valido
);

  localparam logic [15:0] RELOAD = 16'(RELEASE_CYC);

  localparam logic [3:0] KEY_CLEAR = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

  typedef enum logic {
    LIBRE,
    PRESIONADO
  } estado_t;

  estado_t     state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [11:0] digitos_q, digitos_d;
  logic [1:0]  num_dig_q, num_dig_d;
  logic [11:0] valor_q, valor_d;
  logic        valido_q, valido_d;
  logic        tecla;

  // Press tracking: the scanner repeats ctrl while a key is held, so only the first
  // strobe after a quiet period of RELEASE_CYC cycles counts as a keystroke.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tecla   = 1'b0;
    case (state_q)
      LIBRE: begin
        if (ctrl) begin
          tecla   = 1'b1;
          timer_d = RELOAD;
          state_d = PRESIONADO;
        end
      end
      PRESIONADO: begin
        if (ctrl) begin
          timer_d = RELOAD;
        end else if (timer_q <= 16'd1) begin
          timer_d = '0;
          state_d = LIBRE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = LIBRE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    digitos_d = digitos_q;
    num_dig_d = num_dig_q;
    valor_d   = valor_q;
    valido_d  = 1'b0;
    if (tecla) begin
      if (boton <= KEY_MAX_DIGIT) begin
        if (num_dig_q != 2'd3) begin
          digitos_d = {digitos_q[7:0], boton};
          num_dig_d = num_dig_q + 2'd1;
        end
      end else if (boton == KEY_CLEAR) begin
        digitos_d = '0;
        num_dig_d = '0;
      end else if (boton == KEY_ENTER) begin
        if (num_dig_q != 2'd0) begin
          valor_d   = digitos_q;
          valido_d  = 1'b1;
          digitos_d = '0;
          num_dig_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LIBRE;
      timer_q   <= '0;
      digitos_q <= '0;
      num_dig_q <= '0;
      valor_q   <= '0;
      valido_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      digitos_q <= digitos_d;
      num_dig_q <= num_dig_d;
      valor_q   <= valor_d;
      valido_q  <= valido_d;
    end
  end

  assign digitos = digitos_q;
  assign num_dig = num_dig_q;
  assign lleno   = (num_dig_q == 2'd3);
  assign valor   = valor_q;
  assign valido  = valido_q;

endmodule
